// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass and a per-register
// pending-write scoreboard used by decode for RAW hazard detection.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int PEND_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  output logic [NREAD-1:0]         rbusy,
  output logic                     err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] regs  [DEPTH];
  logic [PEND_W-1:0] count [DEPTH];

  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  wr_multi;
  logic [DATA_W-1:0] wr_val [DEPTH];
  logic [DEPTH-1:0]  inc;
  logic [DEPTH-1:0]  underflow;
  logic              iss_fire;

  assign iss_ready = (count[iss_addr] != PEND_MAX) || (iss_addr == '0);
  assign iss_fire  = iss_valid && iss_ready;

  // Register 0 is excluded entirely, so it never bypasses, counts or flags errors.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      wr_hit[r]    = 1'b0;
      wr_multi[r]  = 1'b0;
      wr_val[r]    = '0;
      inc[r]       = 1'b0;
      underflow[r] = 1'b0;
    end
    for (int r = 1; r < DEPTH; r++) begin
      for (int k = 0; k < NWRITE; k++) begin
        if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          if (wr_hit[r]) wr_multi[r] = 1'b1;
          wr_hit[r] = 1'b1;
          wr_val[r] = wdata[k*DATA_W +: DATA_W];
        end
      end
      inc[r]       = iss_fire && (iss_addr == ADDR_W'(r));
      underflow[r] = wr_hit[r] && !inc[r] && (count[r] == '0);
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      logic [ADDR_W-1:0] a;
      a = raddr[i*ADDR_W +: ADDR_W];
      rdata[i*DATA_W +: DATA_W] = wr_hit[a] ? wr_val[a] : regs[a];
      rbusy[i] = (count[a] - PEND_W'(wr_hit[a])) != '0;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r]  <= '0;
        count[r] <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
        // Simultaneous issue and writeback cancel; underflow saturates at 0.
        case ({inc[r], wr_hit[r]})
          2'b10:   count[r] <= count[r] + 1'b1;
          2'b01:   if (count[r] != '0) count[r] <= count[r] - 1'b1;
          default: count[r] <= count[r];
        endcase
      end
      err <= err | (|underflow) | (|wr_multi);
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: bypass, scoreboard counting,
// saturation, register 0, write conflicts, underflow and async reset.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        err;

  int test_count = 0;
  int fail_count = 0;

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [4:0] ia, input logic [1:0] w,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    iss_valid = iv;
    iss_addr  = ia;
    we        = w;
    waddr     = {wa1, wa0};
    wdata     = {wd1, wd0};
    raddr     = {ra1, ra0};
    #1;
  endtask

  // Let the falling edge commit, then drop the one-shot issue/write strobes.
  task automatic step();
    @(negedge clk);
    #1;
    iss_valid = 1'b0;
    we        = '0;
    #1;
  endtask

  task automatic pulseReset();
    #2 rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    iss_valid = 1'b0; iss_addr = '0; we = '0; waddr = '0; wdata = '0; raddr = '0;
    #3 rst = 1'b0;

    applyStimulus(0, 5, 2'b00, 0, 0, 0, 0, 5, 0);
    checkOutput("rst_rdata", rdata[31:0], 32'h0);
    checkOutput("rst_rbusy", {30'b0, rbusy}, 32'h0);
    checkOutput("rst_ready", {31'b0, iss_ready}, 32'h1);
    checkOutput("rst_err", {31'b0, err}, 32'h0);

    // Build r5 = DEADBEEF with count 2 and err set, then reset mid-cycle.
    applyStimulus(1, 5, 2'b00, 0, 0, 0, 0, 5, 0); step();
    applyStimulus(1, 5, 2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 0); step();
    applyStimulus(1, 5, 2'b00, 0, 0, 0, 0, 5, 0); step();
    applyStimulus(0, 0, 2'b01, 20, 32'h1, 0, 0, 5, 0); step();
    applyStimulus(0, 5, 2'b00, 0, 0, 0, 0, 5, 0);
    checkOutput("pre_rst_rdata", rdata[31:0], 32'hDEADBEEF);
    checkOutput("pre_rst_rbusy", {31'b0, rbusy[0]}, 32'h1);
    checkOutput("pre_rst_err", {31'b0, err}, 32'h1);
    pulseReset();
    checkOutput("mid_rst_rdata", rdata[31:0], 32'h0);
    checkOutput("mid_rst_rbusy", {31'b0, rbusy[0]}, 32'h0);
    checkOutput("mid_rst_ready", {31'b0, iss_ready}, 32'h1);
    checkOutput("mid_rst_err", {31'b0, err}, 32'h0);
    #1 rst = 1'b0;

    // Issue then writeback with bypass.
    applyStimulus(1, 7, 2'b00, 0, 0, 0, 0, 7, 0); step();
    applyStimulus(0, 7, 2'b00, 0, 0, 0, 0, 7, 0);
    checkOutput("iss_rbusy", {31'b0, rbusy[0]}, 32'h1);
    applyStimulus(0, 7, 2'b01, 7, 32'h1234, 0, 0, 7, 0);
    checkOutput("byp_rdata", rdata[31:0], 32'h1234);
    checkOutput("byp_rbusy", {31'b0, rbusy[0]}, 32'h0);
    step();
    checkOutput("wb_rdata", rdata[31:0], 32'h1234);
    checkOutput("wb_rbusy", {31'b0, rbusy[0]}, 32'h0);
    checkOutput("wb_err", {31'b0, err}, 32'h0);

    // Saturation at three outstanding writes.
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1, 3, 2'b00, 0, 0, 0, 0, 3, 0);
      checkOutput("sat_ready_pre", {31'b0, iss_ready}, 32'h1);
      step();
    end
    applyStimulus(0, 3, 2'b00, 0, 0, 0, 0, 3, 0);
    checkOutput("sat_ready", {31'b0, iss_ready}, 32'h0);
    applyStimulus(1, 3, 2'b00, 0, 0, 0, 0, 3, 0); step();
    applyStimulus(0, 3, 2'b00, 0, 0, 0, 0, 3, 0);
    checkOutput("sat_hold", {31'b0, iss_ready}, 32'h0);
    applyStimulus(0, 3, 2'b01, 3, 32'h33, 0, 0, 3, 0);
    checkOutput("sat_wb1_rbusy", {31'b0, rbusy[0]}, 32'h1);
    step();
    checkOutput("sat_wb1_ready", {31'b0, iss_ready}, 32'h1);
    checkOutput("sat_wb1_busy", {31'b0, rbusy[0]}, 32'h1);
    applyStimulus(0, 3, 2'b01, 3, 32'h34, 0, 0, 3, 0); step();
    applyStimulus(0, 3, 2'b01, 3, 32'h35, 0, 0, 3, 0);
    checkOutput("sat_last_rbusy", {31'b0, rbusy[0]}, 32'h0);
    step();
    checkOutput("sat_err", {31'b0, err}, 32'h0);

    // Same-cycle issue and writeback on r9 with count 1.
    applyStimulus(1, 9, 2'b00, 0, 0, 0, 0, 0, 9); step();
    applyStimulus(1, 9, 2'b01, 9, 32'h99, 0, 0, 0, 9);
    checkOutput("both_rbusy", {31'b0, rbusy[1]}, 32'h0);
    checkOutput("both_rdata", rdata[63:32], 32'h99);
    step();
    applyStimulus(0, 9, 2'b00, 0, 0, 0, 0, 0, 9);
    checkOutput("both_next_rbusy", {31'b0, rbusy[1]}, 32'h1);
    checkOutput("both_next_rdata", rdata[63:32], 32'h99);
    applyStimulus(0, 9, 2'b01, 9, 32'h99, 0, 0, 0, 9); step();
    checkOutput("both_err", {31'b0, err}, 32'h0);

    // Register 0 is immune to writes, issues and conflicts.
    applyStimulus(1, 0, 2'b01, 0, 32'hFF, 0, 0, 0, 0);
    checkOutput("r0_byp", rdata[31:0], 32'h0);
    checkOutput("r0_rbusy", {31'b0, rbusy[0]}, 32'h0);
    checkOutput("r0_ready", {31'b0, iss_ready}, 32'h1);
    step();
    checkOutput("r0_rdata", rdata[31:0], 32'h0);
    checkOutput("r0_err", {31'b0, err}, 32'h0);
    applyStimulus(0, 0, 2'b11, 0, 32'h1, 0, 32'h2, 0, 0); step();
    checkOutput("r0_conflict_err", {31'b0, err}, 32'h0);

    // Underflow: write with no outstanding issue still stores data.
    applyStimulus(0, 0, 2'b01, 12, 32'h5555, 0, 0, 12, 0);
    checkOutput("uf_byp", rdata[31:0], 32'h5555);
    step();
    checkOutput("uf_rdata", rdata[31:0], 32'h5555);
    checkOutput("uf_err", {31'b0, err}, 32'h1);
    pulseReset();
    #1 rst = 1'b0;
    #1;
    checkOutput("uf_rst_err", {31'b0, err}, 32'h0);
    checkOutput("uf_rst_rdata", rdata[31:0], 32'h0);

    // Write-port conflict: higher port wins, err is sticky.
    applyStimulus(0, 0, 2'b11, 4, 32'hA, 4, 32'hB, 4, 0);
    checkOutput("conf_byp", rdata[31:0], 32'hB);
    step();
    checkOutput("conf_rdata", rdata[31:0], 32'hB);
    checkOutput("conf_err", {31'b0, err}, 32'h1);
    step(); step(); step();
    checkOutput("conf_sticky", {31'b0, err}, 32'h1);
    applyStimulus(0, 0, 2'b11, 2, 32'h22, 6, 32'h66, 2, 6); step();
    checkOutput("dual_rd0", rdata[31:0], 32'h22);
    checkOutput("dual_rd1", rdata[63:32], 32'h66);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
